// File: rtl/branch_flush_ctrl_pkg.sv
// Shared definitions for the branch/jump redirect and flush controller:
// FSM state encoding, the default flush length and the flush counter width.
package branch_flush_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Default number of cycles flush_fd/flush_dx stay high after a redirect.
   localparam int FLUSH_CYCLES_DEF = 2;

   // Width of the flush down-counter; it covers FLUSH_CYCLES up to 7.
   localparam int CNT_FIELD_W = 3;

endpackage

// File: rtl/branch_taken_eval.sv
// Combinational taken/not-taken decision for the instruction in X.
// Type flags are nominally one-hot; if several are set, their conditions
// are simply ORed together.
module branch_taken_eval
   import branch_flush_ctrl_pkg::*;
(
   input  logic ex_valid,
   input  logic ex_is_jump,
   input  logic ex_is_bex,
   input  logic ex_is_bne,
   input  logic ex_is_blt,
   input  logic ex_neq,
   input  logic ex_lt,
   input  logic ex_rstatus_nz,
   output logic taken
);

   // A bubble never redirects; otherwise any satisfied transfer condition does.
   always_comb begin
      taken = ex_valid & (ex_is_jump
                        | (ex_is_bex & ex_rstatus_nz)
                        | (ex_is_bne & ex_neq)
                        | (ex_is_blt & ex_lt));
   end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Redirect/flush sequencer for the branch resolution path.
// The pipeline predicts not-taken; a taken transfer in X produces a one-cycle
// registered PC redirect and FLUSH_CYCLES cycles of F/D and D/X flush. If the
// front end is stalled the target is parked in HOLD until the stall clears.
// Optional feature: define BRANCH_STATS_EN to build the taken/flush counters;
// otherwise stat_taken and stat_flush are tied to zero.
module branch_flush_ctrl
   import branch_flush_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int CNT_W        = 32
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_is_jump,
   input  logic             ex_is_bex,
   input  logic             ex_is_bne,
   input  logic             ex_is_blt,
   input  logic             ex_neq,
   input  logic             ex_lt,
   input  logic             ex_rstatus_nz,
   input  logic [31:0]      ex_target,
   input  logic             stall_in,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_fd,
   output logic             flush_dx,
   output logic             busy,
   output logic [CNT_W-1:0] stat_taken,
   output logic [CNT_W-1:0] stat_flush
);

   // Counter reload: the first flush cycle is the one entered with this value,
   // and the FSM leaves FLUSH on the unstalled edge that sees zero.
   localparam logic [CNT_FIELD_W-1:0] CNT_INIT = CNT_FIELD_W'(FLUSH_CYCLES - 1);

   state_t                  state;
   state_t                  state_n;
   logic [CNT_FIELD_W-1:0]  cnt;
   logic [CNT_FIELD_W-1:0]  cnt_n;
   logic [31:0]             hold_tgt;
   logic [31:0]             hold_tgt_n;
   logic                    taken;

   logic                    redirect_valid_n;
   logic [31:0]             redirect_pc_n;
   logic                    flush_n;
   logic                    busy_n;

   branch_taken_eval u_taken_eval (
      .ex_valid      (ex_valid),
      .ex_is_jump    (ex_is_jump),
      .ex_is_bex     (ex_is_bex),
      .ex_is_bne     (ex_is_bne),
      .ex_is_blt     (ex_is_blt),
      .ex_neq        (ex_neq),
      .ex_lt         (ex_lt),
      .ex_rstatus_nz (ex_rstatus_nz),
      .taken         (taken)
   );

   // FSM state and flush counter; reset returns to IDLE from anywhere.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Parked target while stalled; stale contents are harmless once state is IDLE.
   always_ff @(posedge clock) begin
      hold_tgt <= hold_tgt_n;
   end

   // Next-state logic: X inputs only matter in IDLE, stalls freeze HOLD and FLUSH.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      hold_tgt_n = hold_tgt;
      case (state)
         IDLE: begin
            if (taken) begin
               if (stall_in) begin
                  state_n    = HOLD;
                  hold_tgt_n = ex_target;
               end else begin
                  state_n = FLUSH;
                  cnt_n   = CNT_INIT;
               end
            end
         end
         HOLD: begin
            if (!stall_in) begin
               state_n = FLUSH;
               cnt_n   = CNT_INIT;
            end
         end
         FLUSH: begin
            if (!stall_in) begin
               if (cnt == '0) begin
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Output next-values: redirect only on entry to FLUSH, flush/busy follow the next state.
   always_comb begin
      redirect_valid_n = 1'b0;
      redirect_pc_n    = redirect_pc;
      if ((state == IDLE) && taken && !stall_in) begin
         redirect_valid_n = 1'b1;
         redirect_pc_n    = ex_target;
      end else if ((state == HOLD) && !stall_in) begin
         redirect_valid_n = 1'b1;
         redirect_pc_n    = hold_tgt;
      end
      flush_n = (state_n == FLUSH);
      busy_n  = (state_n != IDLE);
   end

   // Registered outputs so every output changes only on the clock edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_fd       <= 1'b0;
         flush_dx       <= 1'b0;
         busy           <= 1'b0;
      end else begin
         redirect_valid <= redirect_valid_n;
         redirect_pc    <= redirect_pc_n;
         flush_fd       <= flush_n;
         flush_dx       <= flush_n;
         busy           <= busy_n;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] stat_taken_q;
   logic [CNT_W-1:0] stat_flush_q;

   // Statistics: accepted redirects and cycles spent flushing, wrapping naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_taken_q <= '0;
         stat_flush_q <= '0;
      end else begin
         if (redirect_valid_n) begin
            stat_taken_q <= stat_taken_q + CNT_W'(1);
         end
         if (flush_fd) begin
            stat_flush_q <= stat_flush_q + CNT_W'(1);
         end
      end
   end

   assign stat_taken = stat_taken_q;
   assign stat_flush = stat_flush_q;
`else
   assign stat_taken = '0;
   assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed bench for branch_flush_ctrl with FLUSH_CYCLES=2.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_branch_flush_ctrl;

   logic        clock;
   logic        reset;
   logic        ex_valid;
   logic        ex_is_jump;
   logic        ex_is_bex;
   logic        ex_is_bne;
   logic        ex_is_blt;
   logic        ex_neq;
   logic        ex_lt;
   logic        ex_rstatus_nz;
   logic [31:0] ex_target;
   logic        stall_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_fd;
   logic        flush_dx;
   logic        busy;
   logic [31:0] stat_taken;
   logic [31:0] stat_flush;

   int total;
   int bad;

   branch_flush_ctrl #(
      .FLUSH_CYCLES (2),
      .CNT_W        (32)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ex_valid       (ex_valid),
      .ex_is_jump     (ex_is_jump),
      .ex_is_bex      (ex_is_bex),
      .ex_is_bne      (ex_is_bne),
      .ex_is_blt      (ex_is_blt),
      .ex_neq         (ex_neq),
      .ex_lt          (ex_lt),
      .ex_rstatus_nz  (ex_rstatus_nz),
      .ex_target      (ex_target),
      .stall_in       (stall_in),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_fd       (flush_fd),
      .flush_dx       (flush_dx),
      .busy           (busy),
      .stat_taken     (stat_taken),
      .stat_flush     (stat_flush)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Check all control outputs; redirect_pc only matters while redirect_valid is high.
   task automatic expect_out(input string tag, input logic rv, input logic [31:0] pc,
                             input logic fl, input logic bz);
      chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
      if (rv) chk({tag, ".redirect_pc"}, redirect_pc, pc);
      chk({tag, ".flush_fd"}, {31'd0, flush_fd}, {31'd0, fl});
      chk({tag, ".flush_dx"}, {31'd0, flush_dx}, {31'd0, fl});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
   endtask

   task automatic clear_x();
      ex_valid = 0; ex_is_jump = 0; ex_is_bex = 0; ex_is_bne = 0; ex_is_blt = 0;
      ex_neq = 0; ex_lt = 0; ex_rstatus_nz = 0; ex_target = 32'h0;
   endtask

   task automatic jump(input logic [31:0] tgt);
      clear_x();
      ex_valid = 1; ex_is_jump = 1; ex_target = tgt;
   endtask

   // kind: 0=bne, 1=blt, 2=bex; cond drives the matching ALU/status flag.
   task automatic branch(input int kind, input logic cond, input logic [31:0] tgt);
      clear_x();
      ex_valid = 1; ex_target = tgt;
      case (kind)
         0: begin ex_is_bne = 1; ex_neq = cond; end
         1: begin ex_is_blt = 1; ex_lt = cond; end
         default: begin ex_is_bex = 1; ex_rstatus_nz = cond; end
      endcase
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear_x();
      stall_in = 0;

      // Reset held with a taken jump on X: nothing must come out.
      reset = 1;
      jump(32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out($sformatf("rst%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
         chk($sformatf("rst%0d.redirect_pc", i), redirect_pc, 32'h0);
      end
      chk("rst.stat_taken", stat_taken, 32'd0);
      chk("rst.stat_flush", stat_flush, 32'd0);
      reset = 0;
      clear_x();
      step(); expect_out("idle0", 1'b0, 32'h0, 1'b0, 1'b0);
      step(); expect_out("idle1", 1'b0, 32'h0, 1'b0, 1'b0);

      // Unstalled jump: redirect next cycle, two flush cycles, then idle.
      jump(32'h0000_0040);
      step(); expect_out("jmp.c1", 1'b1, 32'h40, 1'b1, 1'b1);
      clear_x();
      step(); expect_out("jmp.c2", 1'b0, 32'h0, 1'b1, 1'b1);
      step(); expect_out("jmp.c3", 1'b0, 32'h0, 1'b0, 1'b0);

      // A bubble carrying a jump flag never redirects.
      jump(32'h0000_0099);
      ex_valid = 0;
      step(); expect_out("bubble", 1'b0, 32'h0, 1'b0, 1'b0);

      // Conditional branches: false condition ignored, true condition redirects.
      for (int k = 0; k < 3; k++) begin
         branch(k, 1'b0, 32'h0000_001F);
         step(); expect_out($sformatf("br%0d.nt", k), 1'b0, 32'h0, 1'b0, 1'b0);
         branch(k, 1'b1, 32'h0000_001F);
         step(); expect_out($sformatf("br%0d.c1", k), 1'b1, 32'h1F, 1'b1, 1'b1);
         clear_x();
         step(); expect_out($sformatf("br%0d.c2", k), 1'b0, 32'h0, 1'b1, 1'b1);
         step(); expect_out($sformatf("br%0d.c3", k), 1'b0, 32'h0, 1'b0, 1'b0);
      end

      // Taken jr while stalled for 4 cycles: HOLD ignores a different jump meanwhile.
      jump(32'h0000_0123);
      stall_in = 1;
      step(); expect_out("hold.c1", 1'b0, 32'h0, 1'b0, 1'b1);
      jump(32'h0000_0999);
      for (int i = 2; i <= 4; i++) begin
         step(); expect_out($sformatf("hold.c%0d", i), 1'b0, 32'h0, 1'b0, 1'b1);
      end
      stall_in = 0;
      clear_x();
      step(); expect_out("hold.rel", 1'b1, 32'h123, 1'b1, 1'b1);
      step(); expect_out("hold.f2", 1'b0, 32'h0, 1'b1, 1'b1);
      step(); expect_out("hold.end", 1'b0, 32'h0, 1'b0, 1'b0);

      // Taken jump during FLUSH plus one stall cycle: flush stretches to 3, no re-redirect.
      jump(32'h0000_0200);
      step(); expect_out("fl.c1", 1'b1, 32'h200, 1'b1, 1'b1);
      jump(32'h0000_0300);
      stall_in = 1;
      step(); expect_out("fl.c2", 1'b0, 32'h0, 1'b1, 1'b1);
      stall_in = 0;
      step(); expect_out("fl.c3", 1'b0, 32'h0, 1'b1, 1'b1);
      step(); expect_out("fl.end", 1'b0, 32'h0, 1'b0, 1'b0);
      // The same jump, still present once back in IDLE, is taken normally.
      step(); expect_out("b2b.c1", 1'b1, 32'h300, 1'b1, 1'b1);
      clear_x();
      step(); expect_out("b2b.c2", 1'b0, 32'h0, 1'b1, 1'b1);
      step(); expect_out("b2b.c3", 1'b0, 32'h0, 1'b0, 1'b0);

      // Reset in the first FLUSH cycle clears everything next cycle.
      jump(32'h0000_0077);
      step(); expect_out("rfl.c1", 1'b1, 32'h77, 1'b1, 1'b1);
      clear_x();
      reset = 1;
      step(); expect_out("rfl.rst", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("rfl.redirect_pc", redirect_pc, 32'h0);
      reset = 0;
      step(); expect_out("rfl.after", 1'b0, 32'h0, 1'b0, 1'b0);

      // Reset mid-HOLD discards the parked target.
      jump(32'h0000_0055);
      stall_in = 1;
      step(); expect_out("rhold.c1", 1'b0, 32'h0, 1'b0, 1'b1);
      clear_x();
      reset = 1;
      step(); expect_out("rhold.rst", 1'b0, 32'h0, 1'b0, 1'b0);
      reset = 0;
      stall_in = 0;
      step(); expect_out("rhold.after", 1'b0, 32'h0, 1'b0, 1'b0);

      // Statistics over 5 full unstalled jumps after a clean reset.
      reset = 1;
      step();
      reset = 0;
      for (int n = 0; n < 5; n++) begin
         jump(32'h0000_1000 + n);
         step();
         chk($sformatf("st%0d.redirect_pc", n), redirect_pc, 32'h0000_1000 + n);
         clear_x();
         step();
         step();
      end
`ifdef BRANCH_STATS_EN
      chk("stat_taken", stat_taken, 32'd5);
      chk("stat_flush", stat_flush, 32'd10);
`else
      chk("stat_taken", stat_taken, 32'd0);
      chk("stat_flush", stat_flush, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
